// File: rtl/ref_gen_pkg.sv
// Shared constants, state encoding and frequency clamp for the reference-clock transmitter.
// Optional dither build switch: REF_GEN_JITTER_EN (see ref_gen_nco).
package ref_gen_pkg;

   localparam int unsigned ACC_W     = 16;
   localparam int unsigned FREQ_W    = 10;
   localparam int unsigned RAMP_DIV  = 256;
   localparam int unsigned GAP_SHIFT = 8;
   localparam int unsigned RAMP_W    = $clog2(RAMP_DIV);
   localparam int unsigned GAP_W     = 16 + GAP_SHIFT;

   // Increments at 50 MHz, 2^16 scale: 100 / 200 / 125 kHz, matching the PLL limits.
   localparam logic [FREQ_W-1:0] FREQ_MIN_RAW     = FREQ_W'(131);
   localparam logic [FREQ_W-1:0] FREQ_MAX_RAW     = FREQ_W'(262);
   localparam logic [FREQ_W-1:0] FREQ_DEFAULT_RAW = FREQ_W'(163);

   localparam logic [1:0] OP_SET_FREQ   = 2'd0;
   localparam logic [1:0] OP_PHASE_STEP = 2'd1;
   localparam logic [1:0] OP_GAP        = 2'd2;
   localparam logic [1:0] OP_RUN_CTL    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP
   } state_e;

   function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] raw);
      if (raw < FREQ_MIN_RAW) begin
         return FREQ_MIN_RAW;
      end else if (raw > FREQ_MAX_RAW) begin
         return FREQ_MAX_RAW;
      end
      return raw;
   endfunction

endpackage

// File: rtl/ref_gen_nco.sv
// NCO phase accumulator with registered MSB output; REF_GEN_JITTER_EN adds LFSR dither
// of +/-1 LSB on the per-cycle increment.
module ref_gen_nco
   import ref_gen_pkg::*;
(
   input  logic              clk_50,
   input  logic              rst,
   input  logic              advance,
   input  logic              run_next,
   input  logic [FREQ_W-1:0] freq,
   input  logic              step_en,
   input  logic [ACC_W-1:0]  step_val,
   output logic              ref_out
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc;
   logic             ref_q, ref_d;

`ifdef REF_GEN_JITTER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      // Right-shifting Fibonacci form of taps 16,14,13,11.
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      inc    = ACC_W'(freq);
      unique case (lfsr_q[1:0])
         2'b01:   inc = ACC_W'(freq) + ACC_W'(1);
         2'b10:   inc = ACC_W'(freq) - ACC_W'(1);
         default: inc = ACC_W'(freq);
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign inc = ACC_W'(freq);
`endif

   always_comb begin
      acc_d = acc_q + (advance ? inc : '0) + (step_en ? step_val : '0);
      ref_d = run_next & acc_d[ACC_W-1];
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         acc_q <= '0;
         ref_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ref_q <= ref_d;
      end
   end

   assign ref_out = ref_q;

endmodule

// File: rtl/ref_gen.sv
// Programmable reference-clock transmitter: command decode, run/gap FSM and frequency slew
// around ref_gen_nco. Build switch REF_GEN_JITTER_EN enables increment dither in the NCO.
module ref_gen
   import ref_gen_pkg::*;
(
   input  logic              clk_50,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [15:0]       cmd_arg,
   output logic              ref_out,
   output logic              running,
   output logic              gap_active,
   output logic [FREQ_W-1:0] cur_freq
);

   state_e            state_q, state_d;
   logic [FREQ_W-1:0] cur_freq_q, cur_freq_d;
   logic [FREQ_W-1:0] target_q, target_d;
   logic [GAP_W-1:0]  gap_ctr_q, gap_ctr_d;
   logic [RAMP_W-1:0] ramp_ctr_q, ramp_ctr_d;
   logic              accept;
   logic              step_en;

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      state_d    = state_q;
      cur_freq_d = cur_freq_q;
      target_d   = target_q;
      gap_ctr_d  = gap_ctr_q;
      ramp_ctr_d = ramp_ctr_q + RAMP_W'(1);
      step_en    = 1'b0;

      // Slew uses the target held before any same-cycle SET_FREQ.
      if (ramp_ctr_q == RAMP_W'(RAMP_DIV - 1)) begin
         ramp_ctr_d = '0;
         if (cur_freq_q < target_q) begin
            cur_freq_d = cur_freq_q + FREQ_W'(1);
         end else if (cur_freq_q > target_q) begin
            cur_freq_d = cur_freq_q - FREQ_W'(1);
         end
      end

      if (state_q == ST_GAP) begin
         if (gap_ctr_q == GAP_W'(1)) begin
            state_d   = ST_RUN;
            gap_ctr_d = '0;
         end else begin
            gap_ctr_d = gap_ctr_q - GAP_W'(1);
         end
      end

      if (accept) begin
         unique case (cmd_op)
            OP_SET_FREQ:   target_d = clamp_freq(cmd_arg[FREQ_W-1:0]);
            OP_PHASE_STEP: step_en  = 1'b1;
            OP_GAP: begin
               if ((state_q == ST_RUN) && (cmd_arg != '0)) begin
                  state_d   = ST_GAP;
                  gap_ctr_d = GAP_W'(cmd_arg) << GAP_SHIFT;
               end
            end
            OP_RUN_CTL:    state_d = cmd_arg[0] ? ST_RUN : ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_freq_q <= FREQ_DEFAULT_RAW;
         target_q   <= FREQ_DEFAULT_RAW;
         gap_ctr_q  <= '0;
         ramp_ctr_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_freq_q <= cur_freq_d;
         target_q   <= target_d;
         gap_ctr_q  <= gap_ctr_d;
         ramp_ctr_q <= ramp_ctr_d;
      end
   end

   // NCO advances in RUN and GAP so the output resumes phase-coherently after a dropout.
   ref_gen_nco u_nco (
      .clk_50   (clk_50),
      .rst      (rst),
      .advance  (state_q != ST_IDLE),
      .run_next (state_d == ST_RUN),
      .freq     (cur_freq_q),
      .step_en  (step_en),
      .step_val (ACC_W'(cmd_arg)),
      .ref_out  (ref_out)
   );

   assign cmd_ready  = (state_q != ST_GAP);
   assign running    = (state_q != ST_IDLE);
   assign gap_active = (state_q == ST_GAP);
   assign cur_freq   = cur_freq_q;

endmodule

// File: tb/tb_ref_gen.sv
// Self-checking bench for ref_gen: cycle-level behavioural model plus directed and random stimulus.
module tb_ref_gen;

   logic        clk_50 = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        ref_out;
   logic        running;
   logic        gap_active;
   logic [9:0]  cur_freq;

   always #10 clk_50 = ~clk_50;

   ref_gen dut (
      .clk_50     (clk_50),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_arg    (cmd_arg),
      .ref_out    (ref_out),
      .running    (running),
      .gap_active (gap_active),
      .cur_freq   (cur_freq)
   );

   int n_checks = 0;
   int n_fails  = 0;
   bit chk_en   = 1'b0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         if (n_fails <= 20)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: 0 idle, 1 run, 2 gap. Time is an absolute edge count since reset.
   int m_state, m_acc, m_cur, m_tgt, m_cyc, m_gap_end, m_lfsr;
   bit m_accepted;

   function automatic int clamp(input int v);
      if (v < 131) return 131;
      if (v > 262) return 262;
      return v;
   endfunction

   function automatic void model_step();
      int inc, step, nstate, old_tgt;
      bit ok;
      if (rst) begin
         m_state = 0; m_acc = 0; m_cur = 163; m_tgt = 163; m_cyc = 0;
         m_gap_end = 0; m_lfsr = 'hACE1; m_accepted = 1'b0;
         return;
      end
      ok  = cmd_valid && (m_state != 2);
      inc = m_cur;
`ifdef REF_GEN_JITTER_EN
      if ((m_lfsr & 3) == 1) inc = inc + 1;
      else if ((m_lfsr & 3) == 2) inc = inc - 1;
      m_lfsr = (m_lfsr >> 1) |
               ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
`endif
      step    = (ok && cmd_op == 2'd1) ? int'(cmd_arg) : 0;
      m_acc   = (m_acc + ((m_state != 0) ? inc : 0) + step) % 65536;
      old_tgt = m_tgt;
      nstate  = m_state;
      if (m_state == 2 && m_cyc == m_gap_end) nstate = 1;
      if (ok) begin
         case (cmd_op)
            2'd0: m_tgt = clamp(int'(cmd_arg) % 1024);
            2'd2: if (m_state == 1 && cmd_arg != 0) begin
               nstate    = 2;
               m_gap_end = m_cyc + int'(cmd_arg) * 256;
            end
            2'd3: nstate = cmd_arg[0] ? 1 : 0;
            default: ;
         endcase
      end
      if (m_cyc % 256 == 255) begin
         if (m_cur < old_tgt) m_cur = m_cur + 1;
         else if (m_cur > old_tgt) m_cur = m_cur - 1;
      end
      m_state    = nstate;
      m_cyc      = m_cyc + 1;
      m_accepted = ok;
   endfunction

   initial forever begin
      @(posedge clk_50);
      model_step();
   end

   initial forever begin
      @(negedge clk_50);
      if (chk_en) begin
         check("ref_out", int'(ref_out), (m_state == 1 && m_acc >= 32768) ? 1 : 0);
         check("cmd_ready", int'(cmd_ready), (m_state != 2) ? 1 : 0);
         check("running", int'(running), (m_state != 0) ? 1 : 0);
         check("gap_active", int'(gap_active), (m_state == 2) ? 1 : 0);
         check("cur_freq", int'(cur_freq), m_cur);
         check("acc", int'(dut.u_nco.acc_q), m_acc);
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; holds the command until the model says it was accepted.
   task automatic send(input logic [1:0] op, input logic [15:0] arg, output int edges);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      edges     = 0;
      do begin
         @(posedge clk_50);
         @(negedge clk_50);
         edges++;
      end while (!m_accepted && edges < 5000);
      cmd_valid = 1'b0;
      if (!m_accepted) check("accept_timeout", 0, 1);
   endtask

   int e, n;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
      repeat (3) @(negedge clk_50);
      rst    = 1'b0;
      chk_en = 1'b1;
      check("rst_ref_out", int'(ref_out), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_running", int'(running), 0);
      check("rst_gap_active", int'(gap_active), 0);
      check("rst_cur_freq", int'(cur_freq), 163);

      // Start and measure first rise and period.
      send(2'd3, 16'd1, e);
      n = 0;
      do begin @(negedge clk_50); n++; end while (!ref_out && n < 1000);
`ifndef REF_GEN_JITTER_EN
      check("first_rise", n, 202);
`endif
      n = 0;
      do begin @(negedge clk_50); n++; end while (ref_out && n < 1000);
      do begin @(negedge clk_50); n++; end while (!ref_out && n < 2000);
`ifndef REF_GEN_JITTER_EN
      check("period", n, 402);
`endif

      // Quarter-period phase step: 163*604 mod 2^16 + 163 + 0x4000.
      send(2'd1, 16'h4000, e);
`ifndef REF_GEN_JITTER_EN
      check("phase_acc", int'(dut.u_nco.acc_q), 49463);
`endif

      // Clamp high and slew time: 99 steps of 256 cycles.
      send(2'd0, 16'd1000, e);
      n = 0;
      while (cur_freq != 10'd262 && n < 30000) begin @(negedge clk_50); n++; end
      check("freq_max", int'(cur_freq), 262);
      check("ramp_time", (n >= 25089 && n <= 25344) ? 1 : 0, 1);

      // Gap of 4<<8 cycles with a command held through it.
      send(2'd2, 16'd4, e);
      check("gap_ready", int'(cmd_ready), 0);
      check("gap_flag", int'(gap_active), 1);
      send(2'd0, 16'd200, e);
      check("gap_hold_edges", e, 1025);

      // Reset mid-gap.
      send(2'd2, 16'd2, e);
      repeat (100) @(negedge clk_50);
      rst = 1'b1;
      @(negedge clk_50);
      rst = 1'b0;
      check("rstgap_running", int'(running), 0);
      check("rstgap_ready", int'(cmd_ready), 1);
      check("rstgap_cur_freq", int'(cur_freq), 163);
      check("rstgap_ref_out", int'(ref_out), 0);

      // Clamp low: 163 -> 131 in 32 steps.
      send(2'd3, 16'd1, e);
      send(2'd0, 16'd5, e);
      n = 0;
      while (cur_freq != 10'd131 && n < 9000) begin @(negedge clk_50); n++; end
      check("freq_min", int'(cur_freq), 131);

      // Stop while running.
      repeat (300) @(negedge clk_50);
      send(2'd3, 16'd0, e);
      check("stop_running", int'(running), 0);
      check("stop_ref_out", int'(ref_out), 0);
      repeat (50) @(negedge clk_50);

      // Random traffic.
      send(2'd3, 16'd1, e);
      repeat (5000) begin
         rst       = ($urandom_range(0, 999) == 0);
         cmd_valid = ($urandom_range(0, 99) < 25);
         cmd_op    = 2'($urandom_range(0, 3));
         case (cmd_op)
            2'd2:    cmd_arg = 16'($urandom_range(0, 2));
            2'd3:    cmd_arg = ($urandom_range(0, 3) != 0) ? 16'd1 : 16'd0;
            default: cmd_arg = 16'($urandom);
         endcase
         @(negedge clk_50);
      end
      rst = 1'b0; cmd_valid = 1'b0;
      repeat (10) @(negedge clk_50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
